uart_frame_writer: RTL and testbench
====================================

Name: uart_frame_writer

Overview:
Parametrised successor to the single-byte UART-to-memory writer. Consumes byte strobes from the UART receiver, discards a configurable header, packs bytes little-endian into memory words, and writes a fixed-depth frame into block RAM. It signals completion to the downsampling datapath. It sits between the UART RX core and the input image/sample RAM, and can be re-armed for successive frames without reset.

Parameters:
- ADDR_W, 16, address width of target RAM.
- DEPTH, 65536, number of words per frame (1..2^ADDR_W).
- BPW, 1, bytes per memory word (1, 2 or 4).
- HDR_BYTES, 15, leading bytes of each frame discarded before payload (0 allowed).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  arm writer for a new frame (sampled in IDLE or DONE).
- abort  in  1  cancel current frame, return to IDLE.
- rx_tick  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  8  received byte.
- wen  out  1  RAM write enable, one-cycle pulse per word.
- addr  out  ADDR_W  RAM word address.
- dout  out  8*BPW  RAM write data.
- busy  out  1  high in SKIP or FILL.
- fin  out  1  frame complete, level.

Behaviour:
- Reset (async, rst_n=0): state IDLE; wen=0, addr=0, dout=0, busy=0, fin=0; all counters and the packing register cleared.
- States: IDLE, SKIP, FILL, DONE.
- IDLE:
  - rx_tick ignored.
  - start=1 -> SKIP if HDR_BYTES>0, else FILL.
  - On that transition: fin<=0, hdr_cnt<=0, byte_idx<=0, word_idx<=0.
  - An rx_tick in the same cycle as start is not consumed.
- SKIP:
  - Each rx_tick increments hdr_cnt.
  - The tick with hdr_cnt==HDR_BYTES-1 -> FILL.
  - No writes occur in SKIP.
- FILL:
  - Each rx_tick stores rx_data into lane byte_idx of the pack register. Lane 0 is bits [7:0], so the first byte received is least significant.
  - byte_idx increments, wrapping at BPW.
  - On the tick that fills lane BPW-1: next cycle wen=1, dout=assembled word, addr=word_idx; then word_idx increments.
  - Write latency is exactly one cycle after the completing rx_tick.
  - wen is low on all other cycles; addr and dout hold their last values when wen=0.
- Frame end: the write to word_idx==DEPTH-1 moves the block to DONE in the same cycle wen is asserted. fin=1 from the next cycle.
- DONE:
  - fin held high and rx_tick ignored.
  - addr returns to 0 one cycle after entry.
  - start=1 re-arms exactly as from IDLE (fin cleared on the transition).
- abort=1 in any state:
  - Next state IDLE, fin=0, no wen.
  - A partially packed word is discarded; already-written words remain in RAM.
  - abort has priority over start and rx_tick.
- Back-to-back rx_tick on consecutive cycles: every tick is consumed, and wen may assert on consecutive cycles.
- The word counter is ADDR_W+1 bits internally, so DEPTH=2^ADDR_W terminates correctly without address wrap. addr never exceeds DEPTH-1.
- busy = (state==SKIP) | (state==FILL).

Test Plan:
All scenarios use ADDR_W=2, DEPTH=4, BPW=2, HDR_BYTES=3 unless noted.
- Reset mid-frame: assert rst_n=0 after 5 bytes -> all outputs 0 immediately (async); state IDLE; no wen after release until start.
- Nominal frame: start, then bytes 0xA0,0xA1,0xA2 (header), then 0x11..0x18 -> exactly 4 wen pulses with addr/dout 0/0x1211, 1/0x1413, 2/0x1615, 3/0x1817. Each wen is one cycle after the 2nd byte of its pair. fin=1 the cycle after the addr-3 write; busy=0 from then.
- Ignored strobes: 3 rx_tick in IDLE and 2 in DONE -> no wen, no state change. Re-start from DONE with 0x00..0x0A -> fin drops on the start edge and the frame rewrites addr 0..3 with 0x0403, 0x0605, 0x0807, 0x0A09.
- Abort: after header plus 3 payload bytes (one word written, one half-word), pulse abort -> no further wen; fin=0; state IDLE. A subsequent start restarts at the header with addr 0.
- Back-to-back ticks, HDR_BYTES=0, BPW=1: rx_tick high for 4 consecutive cycles with 0xF0..0xF3 -> wen high for 4 consecutive cycles, addr 0..3; fin=1 after.
- Simultaneous start and rx_tick in IDLE -> that byte is not counted as header. Verify by having the first payload word equal bytes 4 and 5 of the stream that follows the start cycle.

Source files
------------

// File: rtl/uart_frame_writer.sv
// Frame writer between the UART receiver and the sample RAM: drops a fixed header,
// packs payload bytes little-endian into words and writes one frame of DEPTH words.
module uart_frame_writer #(
   parameter int ADDR_W    = 16,
   parameter int DEPTH     = 65536,
   parameter int BPW       = 1,
   parameter int HDR_BYTES = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic                rx_tick,
   input  logic [7:0]          rx_data,
   output logic                wen,
   output logic [ADDR_W-1:0]   addr,
   output logic [8*BPW-1:0]    dout,
   output logic                busy,
   output logic                fin
);

   localparam int WORD_W = ADDR_W + 1;
   localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int HDR_W  = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

   localparam logic [HDR_W-1:0]  HDR_LAST  = HDR_W'((HDR_BYTES > 0) ? HDR_BYTES - 1 : 0);
   localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(BPW - 1);
   localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_SKIP, S_FILL, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [HDR_W-1:0]    hdr_cnt_q, hdr_cnt_d;
   logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
   logic [WORD_W-1:0]   word_idx_q, word_idx_d;
   logic [8*BPW-1:0]    pack_q, pack_d;
   logic                wen_q, wen_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [8*BPW-1:0]    dout_q, dout_d;
   logic                fin_q, fin_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         hdr_cnt_q  <= '0;
         byte_idx_q <= '0;
         word_idx_q <= '0;
         pack_q     <= '0;
         wen_q      <= 1'b0;
         addr_q     <= '0;
         dout_q     <= '0;
         fin_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hdr_cnt_q  <= hdr_cnt_d;
         byte_idx_q <= byte_idx_d;
         word_idx_q <= word_idx_d;
         pack_q     <= pack_d;
         wen_q      <= wen_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         fin_q      <= fin_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hdr_cnt_d  = hdr_cnt_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      pack_d     = pack_q;
      wen_d      = 1'b0;
      addr_d     = addr_q;
      dout_d     = dout_q;
      fin_d      = fin_q;

      if (abort) begin
         // Partial word is dropped; words already in RAM stay there.
         state_d    = S_IDLE;
         fin_d      = 1'b0;
         hdr_cnt_d  = '0;
         byte_idx_d = '0;
         word_idx_d = '0;
         pack_d     = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (state_q == S_DONE) begin
                  addr_d = '0;
                  fin_d  = 1'b1;
               end
               if (start) begin
                  state_d    = (HDR_BYTES > 0) ? S_SKIP : S_FILL;
                  fin_d      = 1'b0;
                  hdr_cnt_d  = '0;
                  byte_idx_d = '0;
                  word_idx_d = '0;
                  pack_d     = '0;
               end
            end
            S_SKIP: begin
               if (rx_tick) begin
                  hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
                  if (hdr_cnt_q == HDR_LAST) state_d = S_FILL;
               end
            end
            S_FILL: begin
               if (rx_tick) begin
                  for (int i = 0; i < BPW; i++) begin
                     if (byte_idx_q == BIDX_W'(i)) pack_d[i*8 +: 8] = rx_data;
                  end
                  if (byte_idx_q == BYTE_LAST) begin
                     byte_idx_d = '0;
                     wen_d      = 1'b1;
                     dout_d     = pack_d;
                     addr_d     = word_idx_q[ADDR_W-1:0];
                     word_idx_d = word_idx_q + WORD_W'(1);
                     // The final write and the move to DONE land on the same edge.
                     if (word_idx_q == WORD_LAST) state_d = S_DONE;
                  end else begin
                     byte_idx_d = byte_idx_q + BIDX_W'(1);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign wen  = wen_q;
   assign addr = addr_q;
   assign dout = dout_q;
   assign fin  = fin_q;
   assign busy = (state_q == S_SKIP) || (state_q == S_FILL);

endmodule

// File: tb/tb_uart_frame_writer.sv
// Directed bench: unit A uses 2-byte words with a 3-byte header, unit B uses
// byte words with no header for the back-to-back strobe case.
module tb_uart_frame_writer;

   logic        clk;
   logic        rst_n;
   logic        start_a, abort_a, rx_tick_a;
   logic [7:0]  rx_data_a;
   logic        wen_a, busy_a, fin_a;
   logic [1:0]  addr_a;
   logic [15:0] dout_a;
   logic        start_b, abort_b, rx_tick_b;
   logic [7:0]  rx_data_b;
   logic        wen_b, busy_b, fin_b;
   logic [1:0]  addr_b;
   logic [7:0]  dout_b;

   int checks = 0;
   int errors = 0;
   int wen_cnt_a = 0;
   int wen_cnt_b = 0;
   logic [17:0] exp_q[$];

   uart_frame_writer #(.ADDR_W(2), .DEPTH(4), .BPW(2), .HDR_BYTES(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
      .rx_tick(rx_tick_a), .rx_data(rx_data_a), .wen(wen_a), .addr(addr_a),
      .dout(dout_a), .busy(busy_a), .fin(fin_a)
   );

   uart_frame_writer #(.ADDR_W(2), .DEPTH(4), .BPW(1), .HDR_BYTES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
      .rx_tick(rx_tick_b), .rx_data(rx_data_b), .wen(wen_b), .addr(addr_b),
      .dout(dout_b), .busy(busy_b), .fin(fin_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wen_a === 1'b1) wen_cnt_a++;
      if (wen_b === 1'b1) wen_cnt_b++;
   end

   // driver tasks: all called and returning at posedge + 1
   task automatic tick_a(input logic [7:0] b);
      rx_tick_a = 1'b1;
      rx_data_a = b;
      @(posedge clk); #1;
      rx_tick_a = 1'b0;
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
   endtask

   task automatic pulse_abort_a();
      abort_a = 1'b1;
      @(posedge clk); #1;
      abort_a = 1'b0;
   endtask

   task automatic test_reset();
      int snap;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({wen_a, addr_a, dout_a, busy_a, fin_a} !== 21'd0) begin
         errors++; $display("FAIL reset_a: got %h required 0", {wen_a, addr_a, dout_a, busy_a, fin_a});
      end
      checks++;
      if ({wen_b, addr_b, dout_b, busy_b, fin_b} !== 13'd0) begin
         errors++; $display("FAIL reset_b: got %h required 0", {wen_b, addr_b, dout_b, busy_b, fin_b});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      pulse_start_a();
      for (int i = 0; i < 5; i++) tick_a(8'h51 + 8'(i));
      checks++;
      if ({wen_a, addr_a, dout_a} !== {1'b1, 2'd0, 16'h5554}) begin
         errors++; $display("FAIL reset_prewrite: got %h required %h", {wen_a, addr_a, dout_a}, {1'b1, 2'd0, 16'h5554});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({wen_a, addr_a, dout_a, busy_a, fin_a} !== 21'd0) begin
         errors++; $display("FAIL reset_async: got %h required 0", {wen_a, addr_a, dout_a, busy_a, fin_a});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      snap = wen_cnt_a;
      for (int i = 0; i < 3; i++) begin
         tick_a(8'h60 + 8'(i));
         checks++;
         if ({wen_a, busy_a, fin_a} !== 3'b000) begin
            errors++; $display("FAIL idle_tick: got %b required 000", {wen_a, busy_a, fin_a});
         end
      end
      @(posedge clk); #1;
      checks++;
      if (wen_cnt_a !== snap) begin
         errors++; $display("FAIL idle_wen_cnt: got %0d required %0d", wen_cnt_a, snap);
      end
   endtask

   task automatic test_nominal();
      logic [17:0] exp;
      int snap;
      snap = wen_cnt_a;
      exp_q.push_back({2'd0, 16'h1211});
      exp_q.push_back({2'd1, 16'h1413});
      exp_q.push_back({2'd2, 16'h1615});
      exp_q.push_back({2'd3, 16'h1817});
      pulse_start_a();
      checks++;
      if ({busy_a, fin_a} !== 2'b10) begin
         errors++; $display("FAIL nom_start: busy/fin got %b required 10", {busy_a, fin_a});
      end
      for (int i = 0; i < 3; i++) begin
         tick_a(8'hA0 + 8'(i));
         checks++;
         if (wen_a !== 1'b0) begin
            errors++; $display("FAIL nom_hdr_wen: got %b required 0", wen_a);
         end
      end
      for (int i = 0; i < 8; i++) begin
         tick_a(8'h11 + 8'(i));
         checks++;
         if (i % 2 == 1) begin
            exp = exp_q.pop_front();
            if ({wen_a, addr_a, dout_a} !== {1'b1, exp}) begin
               errors++; $display("FAIL nom_write: got %h required %h", {wen_a, addr_a, dout_a}, {1'b1, exp});
            end
         end else if (wen_a !== 1'b0) begin
            errors++; $display("FAIL nom_half_wen: got %b required 0", wen_a);
         end
      end
      checks++;
      if ({busy_a, fin_a} !== 2'b00) begin
         errors++; $display("FAIL nom_last_cycle: busy/fin got %b required 00", {busy_a, fin_a});
      end
      @(posedge clk); #1;
      checks++;
      if ({wen_a, addr_a, busy_a, fin_a} !== 5'b0_00_01) begin
         errors++; $display("FAIL nom_done: wen/addr/busy/fin got %b required 0_00_01", {wen_a, addr_a, busy_a, fin_a});
      end
      checks++;
      if (wen_cnt_a - snap !== 4) begin
         errors++; $display("FAIL nom_wen_cnt: got %0d required 4", wen_cnt_a - snap);
      end
   endtask

   task automatic test_ignored_and_restart();
      logic [17:0] exp;
      for (int i = 0; i < 2; i++) begin
         tick_a(8'h77);
         checks++;
         if ({wen_a, busy_a, fin_a} !== 3'b001) begin
            errors++; $display("FAIL done_tick: wen/busy/fin got %b required 001", {wen_a, busy_a, fin_a});
         end
      end
      exp_q.push_back({2'd0, 16'h0403});
      exp_q.push_back({2'd1, 16'h0605});
      exp_q.push_back({2'd2, 16'h0807});
      exp_q.push_back({2'd3, 16'h0A09});
      pulse_start_a();
      checks++;
      if ({busy_a, fin_a} !== 2'b10) begin
         errors++; $display("FAIL restart: busy/fin got %b required 10", {busy_a, fin_a});
      end
      for (int i = 0; i < 11; i++) begin
         tick_a(8'(i));
         if (i >= 4 && i % 2 == 0) begin
            exp = exp_q.pop_front();
            checks++;
            if ({wen_a, addr_a, dout_a} !== {1'b1, exp}) begin
               errors++; $display("FAIL restart_write: got %h required %h", {wen_a, addr_a, dout_a}, {1'b1, exp});
            end
         end
      end
      @(posedge clk); #1;
      checks++;
      if ({busy_a, fin_a} !== 2'b01) begin
         errors++; $display("FAIL restart_fin: busy/fin got %b required 01", {busy_a, fin_a});
      end
   endtask

   task automatic test_abort();
      int snap;
      pulse_start_a();
      for (int i = 0; i < 3; i++) tick_a(8'hB0 + 8'(i));
      tick_a(8'h21);
      tick_a(8'h22);
      checks++;
      if ({wen_a, addr_a, dout_a} !== {1'b1, 2'd0, 16'h2221}) begin
         errors++; $display("FAIL abort_first_word: got %h required %h", {wen_a, addr_a, dout_a}, {1'b1, 2'd0, 16'h2221});
      end
      tick_a(8'h23);
      // abort together with the tick that would complete word 1
      abort_a = 1'b1; rx_tick_a = 1'b1; rx_data_a = 8'h24;
      @(posedge clk); #1;
      abort_a = 1'b0; rx_tick_a = 1'b0;
      checks++;
      if ({wen_a, busy_a, fin_a} !== 3'b000) begin
         errors++; $display("FAIL abort_state: wen/busy/fin got %b required 000", {wen_a, busy_a, fin_a});
      end
      snap = wen_cnt_a;
      for (int i = 0; i < 3; i++) tick_a(8'h99);
      @(posedge clk); #1;
      checks++;
      if (wen_cnt_a !== snap) begin
         errors++; $display("FAIL abort_no_wen: got %0d required %0d", wen_cnt_a, snap);
      end
      pulse_start_a();
      for (int i = 0; i < 3; i++) tick_a(8'h31 + 8'(i));
      tick_a(8'h41);
      tick_a(8'h42);
      checks++;
      if ({wen_a, addr_a, dout_a} !== {1'b1, 2'd0, 16'h4241}) begin
         errors++; $display("FAIL abort_rearm: got %h required %h", {wen_a, addr_a, dout_a}, {1'b1, 2'd0, 16'h4241});
      end
      pulse_abort_a();
      checks++;
      if (busy_a !== 1'b0) begin
         errors++; $display("FAIL abort_idle: busy got %b required 0", busy_a);
      end
   endtask

   task automatic test_start_with_tick();
      start_a = 1'b1; rx_tick_a = 1'b1; rx_data_a = 8'hEE;
      @(posedge clk); #1;
      start_a = 1'b0; rx_tick_a = 1'b0;
      for (int i = 0; i < 4; i++) tick_a(8'hC1 + 8'(i));
      checks++;
      if (wen_a !== 1'b0) begin
         errors++; $display("FAIL start_tick_early: wen got %b required 0", wen_a);
      end
      tick_a(8'hC5);
      checks++;
      if ({wen_a, addr_a, dout_a} !== {1'b1, 2'd0, 16'hC5C4}) begin
         errors++; $display("FAIL start_tick_word: got %h required %h", {wen_a, addr_a, dout_a}, {1'b1, 2'd0, 16'hC5C4});
      end
      pulse_abort_a();
   endtask

   task automatic test_back_to_back();
      int snap;
      snap = wen_cnt_b;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      checks++;
      if ({busy_b, fin_b} !== 2'b10) begin
         errors++; $display("FAIL b2b_start: busy/fin got %b required 10", {busy_b, fin_b});
      end
      rx_tick_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rx_data_b = 8'hF0 + 8'(i);
         @(posedge clk); #1;
         checks++;
         if ({wen_b, addr_b, dout_b} !== {1'b1, 2'(i), 8'hF0 + 8'(i)}) begin
            errors++; $display("FAIL b2b_write: got %h required %h", {wen_b, addr_b, dout_b}, {1'b1, 2'(i), 8'hF0 + 8'(i)});
         end
      end
      rx_tick_b = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({wen_b, busy_b, fin_b} !== 3'b001) begin
         errors++; $display("FAIL b2b_done: wen/busy/fin got %b required 001", {wen_b, busy_b, fin_b});
      end
      checks++;
      if (wen_cnt_b - snap !== 4) begin
         errors++; $display("FAIL b2b_wen_cnt: got %0d required 4", wen_cnt_b - snap);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start_a = 1'b0; abort_a = 1'b0; rx_tick_a = 1'b0; rx_data_a = 8'h00;
      start_b = 1'b0; abort_b = 1'b0; rx_tick_b = 1'b0; rx_data_b = 8'h00;
      test_reset();
      test_nominal();
      test_ignored_and_restart();
      test_abort();
      test_start_with_tick();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
